des_core_arbiter: RTL and testbench

Shares one DES core among NUM_REQ independent requesters.
- Arbitration is round-robin, with one operation outstanding at a time.
- The block latches the winning request and issues it to the core as a single-cycle valid pulse.
- It waits for the core result under a watchdog, then returns the result on the winner's response channel.
- It sits between the crypto clients and the DES core's data/key/mode/verify/valid/ready interface.

---
 rtl/des_pkg.sv | 39 +++
 rtl/des_rr_picker.sv | 39 +++
 rtl/des_core_arbiter.sv | 145 ++++++++++++++
 tb/tb_des_core_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared types and constants for the DES core arbiter and its helpers.
//   DES_BLK_W / DES_KEY_W : block and key widths of the DES core
//   MAX_REQ               : largest requester count supported by the helpers
//   WD_W                  : watchdog counter width (covers timeouts up to 1023)
//   des_mode_e            : encrypt / decrypt selector
//   arb_state_e           : arbiter FSM states
//   get_slice64()         : extracts requester idx's 64-bit field from a packed bus
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int DES_BLK_W = 64;
    localparam int DES_KEY_W = 64;
    localparam int MAX_REQ   = 4;
    localparam int SEL_W     = $clog2(MAX_REQ);
    localparam int EXT_W     = MAX_REQ * 64;
    localparam int WD_W      = 10;

    typedef enum logic {
        DES_ENC = 1'b0,
        DES_DEC = 1'b1
    } des_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    // Callers zero-extend their packed bus to EXT_W so one helper serves
    // every requester count.
    function automatic logic [63:0] get_slice64(input logic [EXT_W-1:0] vec,
                                                input logic [SEL_W-1:0] idx);
        return vec[idx*64 +: 64];
    endfunction

endpackage

// File: rtl/des_rr_picker.sv
// -----------------------------------------------------------------------------
// des_rr_picker
// Purely combinational round-robin picker. Searches req upward starting at
// last_grant+1 with wrap; last_grant itself has the lowest priority.
//   req        : request vector
//   last_grant : index of the most recently served requester
//   grant      : one-hot pick (all zero when req is zero)
//   idx        : binary index of the pick (0 when req is zero)
// -----------------------------------------------------------------------------
module des_rr_picker
    import des_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // leaves a value unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        // Walk from the lowest priority (k = NUM_REQ, i.e. last_grant) to the
        // highest (k = 1); the last hit overwrites earlier ones, so the
        // closest requester after last_grant wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[IDX_W'((int'(last_grant) + k) % NUM_REQ)]) begin
                grant = '0;
                grant[IDX_W'((int'(last_grant) + k) % NUM_REQ)] = 1'b1;
                idx   = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/des_core_arbiter.sv
// -----------------------------------------------------------------------------
// des_core_arbiter
// Shares one DES core among NUM_REQ requesters. Round-robin acceptance, one
// operation in flight, single-cycle issue strobe, watchdog on the result and
// a response returned on the winner's channel.
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   req_valid/ready/data/key/mode : per-requester request channel (64-bit
//                               fields packed as requester i at [64i+63:64i])
//   rsp_valid/ready           : per-requester response handshake
//   rsp_data, rsp_err         : shared result; rsp_err=1 marks a timeout
//   des_*                     : DES core interface
//   busy                      : high whenever an operation is in progress
// -----------------------------------------------------------------------------
module des_core_arbiter
    import des_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit VERIFY_EN      = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*64-1:0]   req_data,
    input  logic [NUM_REQ*64-1:0]   req_key,
    input  logic [NUM_REQ-1:0]      req_mode,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [DES_BLK_W-1:0]    rsp_data,
    output logic                    rsp_err,
    output logic [DES_BLK_W-1:0]    des_data_in,
    output logic [DES_KEY_W-1:0]    des_key_in,
    output logic                    des_mode_in,
    output logic                    des_verify_in,
    output logic                    des_in_valid,
    input  logic                    des_ready,
    input  logic                    des_out_valid,
    input  logic [DES_BLK_W-1:0]    des_data_out,
    output logic                    busy
);

    localparam int              IDX_W   = $clog2(NUM_REQ);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [WD_W-1:0]     wd_cnt;
    des_mode_e           mode_q;
    logic                accept;
    logic [EXT_W-1:0]    data_ext;
    logic [EXT_W-1:0]    key_ext;

    assign data_ext = EXT_W'(req_data);
    assign key_ext  = EXT_W'(req_key);

    des_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx)
    );

    // Offer a grant only in IDLE with the core able to take work. rst_in
    // masks this combinational path so every output reads 0 during reset.
    assign req_ready   = (state == IDLE && des_ready && !rst_in) ? pick_grant : '0;
    assign accept      = |(req_valid & req_ready);
    assign busy        = (state != IDLE);
    assign des_mode_in = mode_q;

    // The latched data/key/mode registers double as the core-facing outputs:
    // they load on acceptance, are valid during ISSUE and hold afterwards.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_in) begin
            state         <= IDLE;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            owner         <= '0;
            wd_cnt        <= '0;
            des_data_in   <= '0;
            des_key_in    <= '0;
            mode_q        <= DES_ENC;
            des_verify_in <= 1'b0;
            des_in_valid  <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner         <= pick_idx;
                        des_data_in   <= get_slice64(data_ext, SEL_W'(pick_idx));
                        des_key_in    <= get_slice64(key_ext, SEL_W'(pick_idx));
                        mode_q        <= des_mode_e'(req_mode[pick_idx]);
                        des_in_valid  <= 1'b1;
                        des_verify_in <= VERIFY_EN;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    des_in_valid  <= 1'b0;
                    des_verify_in <= 1'b0;
                    wd_cnt        <= '0;
                    state         <= WAIT;
                end

                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // A result on the timeout cycle still wins.
                    if (des_out_valid) begin
                        rsp_data  <= des_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        state     <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid  <= '0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_des_core_arbiter
// Randomized bench with a transaction-level reference: the expected winner is
// the first requesting index after the last served one, the expected response
// is the core model's answer (or 0 with err when the core stays silent past
// the watchdog window), and cycle positions follow the documented latencies.
// -----------------------------------------------------------------------------
module tb_des_core_arbiter;
    import des_pkg::*;

    localparam int NR = 2;
    localparam int TO = 20;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NR-1:0]     req_valid, req_ready, req_mode;
    logic [NR-1:0]     rsp_valid, rsp_ready;
    logic [NR*64-1:0]  req_data, req_key;
    logic [63:0]       rsp_data, des_data_in, des_key_in, des_data_out;
    logic              rsp_err, des_mode_in, des_verify_in, des_in_valid;
    logic              des_ready, des_out_valid, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_grant;
    int w;

    always #5 clk_in = ~clk_in;

    des_core_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .VERIFY_EN      (1'b1)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .req_mode      (req_mode),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .des_data_in   (des_data_in),
        .des_key_in    (des_key_in),
        .des_mode_in   (des_mode_in),
        .des_verify_in (des_verify_in),
        .des_in_valid  (des_in_valid),
        .des_ready     (des_ready),
        .des_out_valid (des_out_valid),
        .des_data_out  (des_data_out),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Stand-in for the DES core: the reference vector, otherwise a keyed scramble.
    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k, input logic m);
        if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1 && !m)
            return 64'h85E813540F0AB405;
        return {d[31:0] ^ k[63:32], d[63:32] + k[31:0]} ^ {64{m}};
    endfunction

    function automatic int model_pick(input logic [NR-1:0] pat);
        for (int k = 1; k <= NR; k++)
            if (pat[(last_grant + k) % NR]) return (last_grant + k) % NR;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [63:0] d, input logic [63:0] k, input logic m);
        req_data[i*64 +: 64] = d;
        req_key[i*64 +: 64]  = k;
        req_mode[i]          = m;
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NR; i++) set_req(i, rand64(), rand64(), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        req_valid     = '0;
        rsp_ready     = '0;
        des_ready     = 1'b1;
        des_out_valid = 1'b0;
        des_data_out  = '0;
        repeat (2) @(negedge clk_in);
        rst_in     = 1'b0;
        last_grant = NR - 1;
    endtask

    // One full operation. lat = WAIT cycle (1..TO) on which the core answers;
    // any other value means the core stays silent and the watchdog fires.
    task automatic run_op(input logic [NR-1:0] pat, input int lat, input int rsp_delay,
                          input bit stall, output int got_w);
        int          exp_w, tries;
        logic [63:0] ed, ek, exp_rsp;
        logic        em, exp_err;
        logic [NR-1:0] exp_oh;

        exp_w  = model_pick(pat);
        exp_oh = NR'(1) << exp_w;
        got_w  = -1;
        if (stall) begin
            des_ready = 1'b0;
            req_valid = pat;
            for (int s = 0; s < 3; s++) begin
                #1;
                check("stall_req_ready", {62'd0, req_ready}, 64'd0);
                @(negedge clk_in);
            end
            des_ready = 1'b1;
        end
        req_valid = pat;
        #1;
        tries = 0;
        while (req_ready == '0 && tries < 20) begin
            @(negedge clk_in);
            #1;
            tries++;
        end
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) got_w = i;
        check("grant", {62'd0, req_ready}, {62'd0, exp_oh});
        if (req_ready == '0) return;
        ed = req_data[exp_w*64 +: 64];
        ek = req_key[exp_w*64 +: 64];
        em = req_mode[exp_w];

        // Issue cycle: one cycle after acceptance.
        @(negedge clk_in);
        #1;
        check("issue_valid", {63'd0, des_in_valid}, 64'd1);
        check("issue_data", des_data_in, ed);
        check("issue_key", des_key_in, ek);
        check("issue_mode", {63'd0, des_mode_in}, {63'd0, em});
        check("issue_verify", {63'd0, des_verify_in}, 64'd1);
        check("issue_ready_low", {62'd0, req_ready}, 64'd0);
        // The served requester may now present new fields; the issued ones must hold.
        set_req(exp_w, rand64(), rand64(), 1'($urandom_range(0, 1)));

        exp_rsp = '0;
        exp_err = 1'b1;
        for (int n = 1; n <= TO; n++) begin
            @(negedge clk_in);
            des_out_valid = (n == lat);
            des_data_out  = (n == lat) ? core_fn(ed, ek, em) : rand64();
            if (n == lat) begin
                exp_rsp = core_fn(ed, ek, em);
                exp_err = 1'b0;
            end
            #1;
            if (n == 1) check("in_valid_pulse", {63'd0, des_in_valid}, 64'd0);
            check("early_rsp", {62'd0, rsp_valid}, 64'd0);
            if (n == lat) break;
        end

        @(negedge clk_in);
        des_out_valid = 1'b0;
        des_data_out  = rand64();
        #1;
        check("rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_oh});
        check("rsp_data", rsp_data, exp_rsp);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        check("rsp_held_data", des_data_in, ed);

        // Backpressure: only non-owner ready bits toggle; stray core strobes ignored.
        for (int d = 0; d < rsp_delay; d++) begin
            @(negedge clk_in);
            rsp_ready     = NR'($urandom) & ~exp_oh;
            des_out_valid = 1'($urandom_range(0, 1));
            des_data_out  = rand64();
            #1;
            check("hold_valid", {62'd0, rsp_valid}, {62'd0, exp_oh});
            check("hold_data", rsp_data, exp_rsp);
            check("hold_err", {63'd0, rsp_err}, {63'd0, exp_err});
            check("hold_no_accept", {62'd0, req_ready}, 64'd0);
        end
        @(negedge clk_in);
        rsp_ready     = exp_oh;
        des_out_valid = 1'b0;
        @(negedge clk_in);
        rsp_ready = '0;
        #1;
        check("rsp_drop", {62'd0, rsp_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        last_grant = exp_w;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        req_data = '0;
        req_key  = '0;
        req_mode = '0;
        do_reset();

        // Reset state, with requests pending during reset.
        rst_in    = 1'b1;
        req_valid = '1;
        #1;
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("rst_in_valid", {63'd0, des_in_valid}, 64'd0);
        check("rst_data_in", des_data_in, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        do_reset();

        // Reference encrypt vector, 16-cycle core.
        set_req(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
        run_op(2'b01, 16, 2, 1'b0, w);
        check("t1_owner", 64'(w), 64'd0);

        // Simultaneous requests and fairness from reset.
        do_reset();
        randomize_reqs();
        for (int i = 0; i < 6; i++) begin
            run_op(2'b11, $urandom_range(1, TO), $urandom_range(0, 3), 1'b0, w);
            check("rr_order", 64'(w), 64'(i % 2));
        end

        // Watchdog, then a normal completion; result on the timeout cycle wins.
        run_op(2'b01, 0, 3, 1'b0, w);
        run_op(2'b01, 5, 1, 1'b0, w);
        run_op(2'b10, TO, 1, 1'b0, w);

        // Response backpressure on requester 1 and core not ready in IDLE.
        run_op(2'b10, 4, 5, 1'b1, w);

        // Random traffic.
        for (int i = 0; i < 20; i++) begin
            run_op(NR'($urandom_range(1, 3)), $urandom_range(0, TO + 2),
                   $urandom_range(0, 4), ($urandom_range(0, 3) == 0), w);
        end

        // Reset in WAIT: operation discarded, no response, requester 0 first after.
        req_valid = 2'b10;
        #1;
        for (int t = 0; t < 20 && req_ready == '0; t++) begin
            @(negedge clk_in);
            #1;
        end
        repeat (4) @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check("mid_rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("mid_rst_data_in", des_data_in, 64'd0);
        check("mid_rst_key_in", des_key_in, 64'd0);
        @(negedge clk_in);
        rst_in     = 1'b0;
        req_valid  = '0;
        last_grant = NR - 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_in);
            des_out_valid = (t == 0);
            des_data_out  = rand64();
            #1;
            check("post_rst_no_rsp", {62'd0, rsp_valid}, 64'd0);
            check("post_rst_busy", {63'd0, busy}, 64'd0);
        end
        des_out_valid = 1'b0;
        run_op(2'b11, 3, 0, 1'b0, w);
        check("post_rst_prio", 64'(w), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
